mandelbrot_iter_ctrl: RTL

Initiator-side sequencer for the Mandelbrot ALU. It accepts one pixel coordinate (cr, ci) at a time and starts z at 0. It repeatedly issues start pulses to the ALU, captures the ALU's next-z on finished, and feeds that value back. It stops on divergence (size or overflow) or when the iteration limit is reached. It then returns the iteration count over a valid/ready result port and sits between the pixel scanner and the ALU.

---
 rtl/mandelbrot_iter_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mandelbrot_iter_ctrl.sv
// mandelbrot_iter_ctrl
//
// Sequencer that sits between the pixel scanner and the Mandelbrot ALU. It takes one
// coordinate c = (cr, ci) at a time and starts z at 0. It then keeps starting the ALU,
// feeding each next-z back as the current z. It stops when z diverges (size or overflow
// flag) or when the per-pixel iteration limit is reached. The iteration count is returned
// over a valid/ready result port.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/ready    coordinate handshake (ready only while idle)
//   in_cr, in_ci      signed fixed-point c, format 2.(WIDTH-2)
//   in_max_iter       iteration limit for this pixel (0 = finish immediately)
//   alu_start         one-cycle start pulse to the ALU
//   alu_cr/ci/zr/zi   registered operands, stable from start until finished
//   alu_finished      ALU result valid (only looked at while waiting)
//   alu_next_zr/zi    ALU next z
//   alu_size          |z|^2 > 4 for the current z
//   alu_overflow      next z not representable
//   out_valid/ready   result handshake
//   out_iter          iterations completed
//   out_escaped       1 = diverged, 0 = limit reached

module mandelbrot_iter_ctrl #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ITER_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_cr,
  input  logic [WIDTH-1:0]      in_ci,
  input  logic [ITER_WIDTH-1:0] in_max_iter,

  output logic                  alu_start,
  output logic [WIDTH-1:0]      alu_cr,
  output logic [WIDTH-1:0]      alu_ci,
  output logic [WIDTH-1:0]      alu_zr,
  output logic [WIDTH-1:0]      alu_zi,
  input  logic                  alu_finished,
  input  logic [WIDTH-1:0]      alu_next_zr,
  input  logic [WIDTH-1:0]      alu_next_zi,
  input  logic                  alu_size,
  input  logic                  alu_overflow,

  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ITER_WIDTH-1:0] out_iter,
  output logic                  out_escaped
);

  typedef enum logic [1:0] {StIdle, StStart, StWait, StDone} state_e;

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      cr_q, cr_d;
  logic [WIDTH-1:0]      ci_q, ci_d;
  logic [WIDTH-1:0]      zr_q, zr_d;
  logic [WIDTH-1:0]      zi_q, zi_d;
  logic [ITER_WIDTH-1:0] iter_q, iter_d;
  logic [ITER_WIDTH-1:0] limit_q, limit_d;
  logic                  escaped_q, escaped_d;

  logic [ITER_WIDTH-1:0] iter_inc;
  logic                  diverged;

  assign iter_inc = iter_q + 1'b1;
  assign diverged = alu_size | alu_overflow;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cr_q      <= '0;
      ci_q      <= '0;
      zr_q      <= '0;
      zi_q      <= '0;
      iter_q    <= '0;
      limit_q   <= '0;
      escaped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cr_q      <= cr_d;
      ci_q      <= ci_d;
      zr_q      <= zr_d;
      zi_q      <= zi_d;
      iter_q    <= iter_d;
      limit_q   <= limit_d;
      escaped_q <= escaped_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d = (in_max_iter == '0) ? StDone : StStart;
        end
      end
      StStart: state_d = StWait;
      StWait: begin
        if (alu_finished) begin
          // Divergence wins over the limit check; iter_inc == limit ends before any wrap.
          if (diverged || (iter_inc == limit_q)) begin
            state_d = StDone;
          end else begin
            state_d = StStart;
          end
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next values
  always_comb begin
    cr_d      = cr_q;
    ci_d      = ci_q;
    zr_d      = zr_q;
    zi_d      = zi_q;
    iter_d    = iter_q;
    limit_d   = limit_q;
    escaped_d = escaped_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          cr_d      = in_cr;
          ci_d      = in_ci;
          zr_d      = '0;
          zi_d      = '0;
          iter_d    = '0;
          limit_d   = in_max_iter;
          escaped_d = 1'b0;
        end
      end
      StWait: begin
        if (alu_finished) begin
          if (diverged) begin
            // z and the count are left at the last in-range iteration.
            escaped_d = 1'b1;
          end else begin
            zr_d   = alu_next_zr;
            zi_d   = alu_next_zi;
            iter_d = iter_inc;
          end
        end
      end
      default: ;
    endcase
  end

  // Outputs: decoded from registered state or straight from registers only
  always_comb begin
    in_ready    = (state_q == StIdle);
    alu_start   = (state_q == StStart);
    out_valid   = (state_q == StDone);
    alu_cr      = cr_q;
    alu_ci      = ci_q;
    alu_zr      = zr_q;
    alu_zi      = zi_q;
    out_iter    = iter_q;
    out_escaped = escaped_q;
  end

endmodule
